// File: rtl/xoper_seq.sv
// Keypad expression sequencer: two signed decimal operands plus one operator,
// evaluated as add/sub/mul in one cycle or by a restoring divider.
module xoper_seq #(
  parameter int DATA_W     = 11,
  parameter int MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              busy,
  output logic              err_ovf,
  output logic              err_div0
);

  localparam int MAG_W  = $clog2(10**MAX_DIGITS);
  localparam int BIG_W  = (MAG_W > DATA_W) ? MAG_W : DATA_W;
  localparam int WIDE_W = 2*BIG_W + 4;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int DCNT_W = $clog2(MAX_DIGITS + 1);

  localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);
  localparam logic [DCNT_W-1:0]        DCNT_ONE  = DCNT_W'(1);
  localparam logic [DCNT_W-1:0]        DCNT_MAX  = DCNT_W'(MAX_DIGITS);
  localparam logic signed [WIDE_W-1:0] MAX_POS   = WIDE_W'(2**(DATA_W-1) - 1);
  localparam logic signed [WIDE_W-1:0] MIN_NEG   = ~MAX_POS;

  localparam logic [3:0] K_NINE = 4'd9;
  localparam logic [3:0] K_ADD  = 4'd10;
  localparam logic [3:0] K_SUB  = 4'd11;
  localparam logic [3:0] K_DIV  = 4'd13;
  localparam logic [3:0] K_EQ   = 4'd14;
  localparam logic [3:0] K_CLR  = 4'd15;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;
  typedef enum logic [2:0] {SIGN1, DIG1, SIGN2, DIG2, CALC, DIV, DONE} state_e;

  state_e              state_r, next_state_s;
  op_e                 op_r;
  logic                busy_r, sign1_r, sign2_r;
  logic [MAG_W-1:0]    mag1_r, mag2_r, rem_r, rem_nx_s;
  logic [DCNT_W-1:0]   cnt1_r, cnt2_r;
  logic [CNT_W-1:0]    div_cnt_r;
  logic [DATA_W-1:0]   quot_r, calc_res_r, result_r, q_signed_s;
  logic                result_valid_r, err_ovf_r, err_div0_r;
  logic                key_s, clr_s, digit_s, is_op_s, sign_key_s, ge_s, div0_s;
  logic                range_ovf_s, mag_ovf_s;
  logic [MAG_W:0]      rem_sh_s;
  logic signed [WIDE_W-1:0] mag1_w_s, mag2_w_s, a_s, b_s, calc_s;

  function automatic logic [MAG_W-1:0] acc_digit(input logic [MAG_W-1:0] mag,
                                                 input logic [3:0] d);
    return mag * MAG_W'(4'd10) + MAG_W'(d);
  endfunction

  assign key_s      = key_valid & ~busy_r;
  assign clr_s      = key_s & (key_code == K_CLR);
  assign digit_s    = (key_code <= K_NINE);
  assign is_op_s    = (key_code >= K_ADD) && (key_code <= K_DIV);
  assign sign_key_s = (key_code == K_ADD) || (key_code == K_SUB);
  assign div0_s     = (op_r == OP_DIV) && (mag2_r == '0);

  // Signed full-precision evaluation and overflow detection
  always_comb begin
    mag1_w_s = $signed(WIDE_W'(mag1_r));
    mag2_w_s = $signed(WIDE_W'(mag2_r));
    a_s      = sign1_r ? -mag1_w_s : mag1_w_s;
    b_s      = sign2_r ? -mag2_w_s : mag2_w_s;
    calc_s   = a_s + b_s;
    case (op_r)
      OP_ADD:  calc_s = a_s + b_s;
      OP_SUB:  calc_s = a_s - b_s;
      OP_MUL:  calc_s = a_s * b_s;
      default: calc_s = a_s + b_s;
    endcase
    range_ovf_s = (calc_s > MAX_POS) || (calc_s < MIN_NEG);
    mag_ovf_s   = (mag1_w_s > MAX_POS) || (mag2_w_s > MAX_POS);
  end

  // One restoring-division step on magnitudes; quotient sign applied at the end
  always_comb begin
    rem_sh_s   = {rem_r, quot_r[DATA_W-1]};
    ge_s       = (rem_sh_s >= {1'b0, mag2_r});
    rem_nx_s   = rem_sh_s[MAG_W-1:0];
    if (ge_s) begin
      rem_nx_s = rem_sh_s[MAG_W-1:0] - mag2_r;
    end else begin
      rem_nx_s = rem_sh_s[MAG_W-1:0];
    end
    if (sign1_r ^ sign2_r) begin
      q_signed_s = -quot_r;
    end else begin
      q_signed_s = quot_r;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      SIGN1: begin
        if (key_s && digit_s) next_state_s = DIG1;
        else                  next_state_s = SIGN1;
      end
      DIG1: begin
        if (clr_s)                           next_state_s = SIGN1;
        else if (key_s && is_op_s)           next_state_s = SIGN2;
        else if (key_s && key_code == K_EQ)  next_state_s = CALC;
        else                                 next_state_s = DIG1;
      end
      SIGN2: begin
        if (clr_s)                 next_state_s = SIGN1;
        else if (key_s && digit_s) next_state_s = DIG2;
        else                       next_state_s = SIGN2;
      end
      DIG2: begin
        if (clr_s)                          next_state_s = SIGN1;
        else if (key_s && key_code == K_EQ) next_state_s = CALC;
        else                                next_state_s = DIG2;
      end
      CALC: begin
        if (op_r == OP_DIV && !div0_s) next_state_s = DIV;
        else                           next_state_s = DONE;
      end
      DIV: begin
        if (div_cnt_r == CNT_LAST) next_state_s = DONE;
        else                       next_state_s = DIV;
      end
      DONE:    next_state_s = SIGN1;
      default: next_state_s = SIGN1;
    endcase
  end

  // State register and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SIGN1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == CALC) || (next_state_s == DIV) || (next_state_s == DONE);
    end
  end

  // Operand capture, evaluation, division and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r <= OP_ADD; sign1_r <= 1'b0; sign2_r <= 1'b0;
      mag1_r <= '0; mag2_r <= '0; cnt1_r <= '0; cnt2_r <= '0;
      quot_r <= '0; rem_r <= '0; div_cnt_r <= '0; calc_res_r <= '0;
      result_r <= '0; result_valid_r <= 1'b0; err_ovf_r <= 1'b0; err_div0_r <= 1'b0;
    end else begin
      result_valid_r <= 1'b0;
      if (clr_s) begin
        op_r <= OP_ADD; sign1_r <= 1'b0; sign2_r <= 1'b0;
        mag1_r <= '0; mag2_r <= '0; cnt1_r <= '0; cnt2_r <= '0;
        err_ovf_r <= 1'b0; err_div0_r <= 1'b0;
      end else begin
        case (state_r)
          SIGN1: if (key_s) begin
            if (digit_s) begin
              mag1_r <= MAG_W'(key_code);
              cnt1_r <= DCNT_ONE;
            end else if (sign_key_s) begin
              sign1_r <= (key_code == K_SUB);
            end
          end
          DIG1: if (key_s) begin
            if (digit_s) begin
              if (cnt1_r < DCNT_MAX) begin
                mag1_r <= acc_digit(mag1_r, key_code);
                cnt1_r <= cnt1_r + DCNT_ONE;
              end
            end else if (is_op_s) begin
              op_r <= op_e'(2'(key_code - K_ADD));
            end else if (key_code == K_EQ) begin
              op_r <= OP_ADD; mag2_r <= '0; sign2_r <= 1'b0;
            end
          end
          SIGN2: if (key_s) begin
            if (digit_s) begin
              mag2_r <= MAG_W'(key_code);
              cnt2_r <= DCNT_ONE;
            end else if (sign_key_s) begin
              sign2_r <= (key_code == K_SUB);
            end
          end
          DIG2: if (key_s && digit_s && cnt2_r < DCNT_MAX) begin
            mag2_r <= acc_digit(mag2_r, key_code);
            cnt2_r <= cnt2_r + DCNT_ONE;
          end
          CALC: begin
            err_ovf_r  <= (op_r == OP_DIV) ? mag_ovf_s : (range_ovf_s | mag_ovf_s);
            err_div0_r <= div0_s;
            calc_res_r <= div0_s ? '0 : calc_s[DATA_W-1:0];
            quot_r     <= DATA_W'(mag1_r);
            rem_r      <= '0;
            div_cnt_r  <= '0;
          end
          DIV: begin
            rem_r     <= rem_nx_s;
            quot_r    <= {quot_r[DATA_W-2:0], ge_s};
            div_cnt_r <= div_cnt_r + CNT_ONE;
          end
          DONE: begin
            result_r       <= (op_r == OP_DIV && !err_div0_r) ? q_signed_s : calc_res_r;
            result_valid_r <= 1'b1;
            op_r <= OP_ADD; sign1_r <= 1'b0; sign2_r <= 1'b0;
            mag1_r <= '0; mag2_r <= '0; cnt1_r <= '0; cnt2_r <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;
  assign err_ovf      = err_ovf_r;
  assign err_div0     = err_div0_r;

endmodule

// File: tb/tb_xoper_seq.sv
// Self-checking bench for xoper_seq: scoreboard of expected results pushed on '='
// and popped when result_valid pulses.
module tb_xoper_seq;
  localparam int DATA_W = 11;

  logic              clk = 1'b0;
  logic              rst, key_valid;
  logic [3:0]        key_code;
  logic [DATA_W-1:0] result;
  logic              result_valid, busy, err_ovf, err_div0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic              ovf;
    logic              div0;
    int                lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  xoper_seq #(.DATA_W(DATA_W), .MAX_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .result(result), .result_valid(result_valid), .busy(busy),
    .err_ovf(err_ovf), .err_div0(err_div0)
  );

  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic enter(input logic [31:0] seq, input int n);
    for (int i = 0; i < n; i++) press(seq[4*(n-1-i) +: 4]);
  endtask

  // Press '=', then observe latency, busy cycles and outputs at the result_valid pulse.
  task automatic run_eq(input exp_t e, input bit junk, output exp_t want, output int lat,
                        output int bcnt, output logic [DATA_W-1:0] r,
                        output logic ovf, output logic dz);
    bit got;
    sb_q.push_back(e);
    press(4'd14);
    lat = 0; bcnt = 0; got = 1'b0; r = 'x; ovf = 1'bx; dz = 1'bx;
    while (!got && lat < 40) begin
      if (busy) bcnt++;
      if (junk) begin
        key_valid = 1'b1;
        key_code  = 4'(lat*5 + 1);
      end
      @(negedge clk);
      lat++;
      key_valid = 1'b0;
      if (result_valid) begin
        got = 1'b1; r = result; ovf = err_ovf; dz = err_div0;
      end
    end
    want = sb_q.pop_front();
  endtask

  task automatic test_reset;
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0;
    repeat (3) @(negedge clk);
    tests++; if (result !== '0)         begin fails++; $display("FAIL reset_result: got %h want 000", result); end
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_rv: got %b want 0", result_valid); end
    tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (err_ovf !== 1'b0)      begin fails++; $display("FAIL reset_ovf: got %b want 0", err_ovf); end
    tests++; if (err_div0 !== 1'b0)     begin fails++; $display("FAIL reset_div0: got %b want 0", err_div0); end
    rst = 1'b0;
  endtask

  task automatic test_arith;
    logic [31:0] seqs [8];
    int          lens [8];
    exp_t        exps [8];
    exp_t        w;
    int          lat, bcnt;
    logic [DATA_W-1:0] r;
    logic        ovf, dz;
    seqs = '{32'hB12A5, 32'hBA3BB5, 32'hB0, 32'h25CB40, 32'h999C2, 32'hB512C2, 32'h512C2, 32'hB999B999};
    lens = '{5, 6, 2, 6, 5, 6, 5, 8};
    exps = '{'{11'h7F9, 1'b0, 1'b0, 2}, '{11'h008, 1'b0, 1'b0, 2}, '{11'h000, 1'b0, 1'b0, 2},
             '{11'h418, 1'b0, 1'b0, 2}, '{11'h7CE, 1'b1, 1'b0, 2}, '{11'h400, 1'b0, 1'b0, 2},
             '{11'h400, 1'b1, 1'b0, 2}, '{11'h032, 1'b1, 1'b0, 2}};
    for (int i = 0; i < 8; i++) begin
      enter(seqs[i], lens[i]);
      run_eq(exps[i], 1'b0, w, lat, bcnt, r, ovf, dz);
      tests++; if (lat !== w.lat) begin fails++; $display("FAIL arith%0d_latency: got %0d want %0d", i, lat, w.lat); end
      tests++; if (r !== w.res)   begin fails++; $display("FAIL arith%0d_result: got %h want %h", i, r, w.res); end
      tests++; if (ovf !== w.ovf) begin fails++; $display("FAIL arith%0d_ovf: got %b want %b", i, ovf, w.ovf); end
      tests++; if (dz !== w.div0) begin fails++; $display("FAIL arith%0d_div0: got %b want %b", i, dz, w.div0); end
    end
  endtask

  task automatic test_clear;
    exp_t w;
    int   lat, bcnt;
    logic [DATA_W-1:0] r;
    logic ovf, dz;
    press(4'd15);
    tests++; if (err_ovf !== 1'b0)  begin fails++; $display("FAIL clear_ovf: got %b want 0", err_ovf); end
    tests++; if (result !== 11'h032) begin fails++; $display("FAIL clear_hold: got %h want 032", result); end
    enter(32'h7AF2A3, 6);
    run_eq('{11'h005, 1'b0, 1'b0, 2}, 1'b0, w, lat, bcnt, r, ovf, dz);
    tests++; if (r !== w.res)   begin fails++; $display("FAIL clear_mid_result: got %h want %h", r, w.res); end
    tests++; if (lat !== w.lat) begin fails++; $display("FAIL clear_mid_latency: got %0d want %0d", lat, w.lat); end
  endtask

  task automatic test_div;
    exp_t w;
    int   lat, bcnt;
    logic [DATA_W-1:0] r;
    logic ovf, dz;
    enter(32'hB100D7, 6);
    run_eq('{11'h7F2, 1'b0, 1'b0, 13}, 1'b1, w, lat, bcnt, r, ovf, dz);
    tests++; if (lat !== w.lat)  begin fails++; $display("FAIL div_latency: got %0d want %0d", lat, w.lat); end
    tests++; if (bcnt !== 13)    begin fails++; $display("FAIL div_busy_cycles: got %0d want 13", bcnt); end
    tests++; if (r !== w.res)    begin fails++; $display("FAIL div_result: got %h want %h", r, w.res); end
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL div_busy_end: got %b want 0", busy); end
    tests++; if (dz !== w.div0)  begin fails++; $display("FAIL div_div0: got %b want %b", dz, w.div0); end
    @(negedge clk);
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL div_pulse_width: got %b want 0", result_valid); end
    tests++; if (result !== 11'h7F2)    begin fails++; $display("FAIL div_hold: got %h want 7F2", result); end
    enter(32'h99DB10, 6);
    run_eq('{11'h7F7, 1'b0, 1'b0, 13}, 1'b0, w, lat, bcnt, r, ovf, dz);
    tests++; if (r !== w.res)   begin fails++; $display("FAIL div_neg_divisor_result: got %h want %h", r, w.res); end
    tests++; if (lat !== w.lat) begin fails++; $display("FAIL div_neg_divisor_latency: got %0d want %0d", lat, w.lat); end
  endtask

  task automatic test_div0_digits;
    exp_t w;
    int   lat, bcnt;
    logic [DATA_W-1:0] r;
    logic ovf, dz;
    enter(32'h5D0, 3);
    run_eq('{11'h000, 1'b0, 1'b1, 2}, 1'b0, w, lat, bcnt, r, ovf, dz);
    tests++; if (dz !== w.div0) begin fails++; $display("FAIL div0_flag: got %b want %b", dz, w.div0); end
    tests++; if (r !== w.res)   begin fails++; $display("FAIL div0_result: got %h want %h", r, w.res); end
    tests++; if (lat !== w.lat) begin fails++; $display("FAIL div0_latency: got %0d want %0d", lat, w.lat); end
    enter(32'h1234, 4);
    run_eq('{11'h07B, 1'b0, 1'b0, 2}, 1'b0, w, lat, bcnt, r, ovf, dz);
    tests++; if (r !== w.res)   begin fails++; $display("FAIL max_digits_result: got %h want %h", r, w.res); end
    tests++; if (dz !== w.div0) begin fails++; $display("FAIL max_digits_div0: got %b want %b", dz, w.div0); end
  endtask

  task automatic test_reset_abort;
    exp_t w;
    int   lat, bcnt, extra;
    logic [DATA_W-1:0] r;
    logic ovf, dz;
    enter(32'h6D2, 3);
    press(4'd14);
    repeat (4) @(negedge clk);
    rst = 1'b1; key_valid = 1'b1; key_code = 4'd5;
    @(negedge clk);
    rst = 1'b0; key_valid = 1'b0;
    tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL abort_rv: got %b want 0", result_valid); end
    tests++; if (result !== '0)         begin fails++; $display("FAIL abort_result: got %h want 000", result); end
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (result_valid) extra++;
    end
    tests++; if (extra !== 0) begin fails++; $display("FAIL abort_stray_rv: got %0d pulses want 0", extra); end
    enter(32'h3A4, 3);
    run_eq('{11'h007, 1'b0, 1'b0, 2}, 1'b0, w, lat, bcnt, r, ovf, dz);
    tests++; if (r !== w.res)   begin fails++; $display("FAIL after_abort_result: got %h want %h", r, w.res); end
    tests++; if (lat !== w.lat) begin fails++; $display("FAIL after_abort_latency: got %0d want %0d", lat, w.lat); end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_clear;
    test_div;
    test_div0_digits;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
